id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register of the pipelined CPU.
- Captures decoded operands, register addresses, immediate, PC and control bundle at the end of ID.
- Presents them to EX, where rs1/rs2 data feed the 4:1 forwarding operand muxes and the rs1/rs2 addresses feed the forwarding unit.
- Supports hazard stall (hold) and flush (bubble insertion).

Parameters:
- DATA_WIDTH, 32, width of PC, register data and immediate
- REG_ADDR_WIDTH, 5, register-file address width
- CTRL_WIDTH, 16, width of opaque control bundle from the decoder
- CNT_WIDTH, 16, bubble-counter width (only with optional feature)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_stall  in  1  hold all stage contents (from hazard unit)
- i_flush  in  1  replace stage contents with a bubble (branch/jump taken)
- i_valid  in  1  ID instruction valid
- i_pc  in  DATA_WIDTH  PC of ID instruction
- i_rs1_data  in  DATA_WIDTH  register-file read data 1
- i_rs2_data  in  DATA_WIDTH  register-file read data 2
- i_imm  in  DATA_WIDTH  sign-extended immediate
- i_rs1_addr  in  REG_ADDR_WIDTH  source 1 address
- i_rs2_addr  in  REG_ADDR_WIDTH  source 2 address
- i_rd_addr  in  REG_ADDR_WIDTH  destination address
- i_funct3  in  3  funct3 field for ALU control / branch compare
- i_ctrl  in  CTRL_WIDTH  control bundle; bit 0 = reg_write, bit 1 = mem_read, bit 2 = mem_write
- o_valid  out  1  EX instruction valid
- o_pc, o_rs1_data, o_rs2_data, o_imm  out  DATA_WIDTH each  registered copies
- o_rs1_addr, o_rs2_addr, o_rd_addr  out  REG_ADDR_WIDTH each  registered copies
- o_funct3  out  3  registered copy
- o_ctrl  out  CTRL_WIDTH  registered control bundle
- o_bubble_cnt  out  CNT_WIDTH  flush counter (only with ID_EX_BUBBLE_CNT_EN)

Behaviour:
- All outputs are registered directly; no combinational input-to-output path.
- Latency: 1 cycle from ID inputs to EX outputs.
- Reset (i_rst=1, asynchronous): every output = 0, including o_valid, o_ctrl and o_bubble_cnt. Release takes effect at the next rising edge.
- Update priority at each rising edge: i_flush > i_stall > load.
  - flush: all outputs = 0 (NOP bubble: o_valid=0, o_ctrl=0, o_rd_addr=0).
  - stall (no flush): all outputs hold their previous values.
  - load: every output takes its corresponding input.
- Simultaneous i_flush=1 and i_stall=1: flush wins; the bubble is written.
- Load with i_valid=0: o_ctrl is written as 0 regardless of i_ctrl, so EX never writes a register or memory for an invalid slot. Other fields are copied.
- Load with i_rd_addr=0: ctrl bit 0 (reg_write) is forced to 0 in o_ctrl, so x0 is never a forwarding source. Other bits pass unchanged.
- Stall is level-sensitive; consecutive stall cycles hold indefinitely.

Optional Feature:
- Macro: ID_EX_BUBBLE_CNT_EN
- Defined:
  - Port o_bubble_cnt exists.
  - Increments by 1 at each rising edge where i_flush=1.
  - Saturates at all-ones; does not wrap.
  - Cleared only by i_rst.
  - Unaffected by i_stall.
- Undefined: port and counter logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-operation: load PC 0x0000_0040, then assert i_rst between clock edges -> all outputs 0 immediately, without waiting for an edge.
- Plain load: i_valid=1, i_pc=0x100, i_rs1_data=0xDEADBEEF, i_rd_addr=5, i_ctrl=0x0001 -> one edge later o_pc=0x100, o_rs1_data=0xDEADBEEF, o_rd_addr=5, o_ctrl=0x0001, o_valid=1.
- Stall hold: after the load above, i_stall=1 for 3 cycles with new inputs i_pc=0x104 -> outputs stay at i_pc=0x100 values for all 3 cycles; release -> o_pc=0x104 next edge.
- Flush vs stall: i_flush=1 and i_stall=1 together -> next edge o_valid=0, o_ctrl=0, o_rd_addr=0; o_bubble_cnt 0->1 when ID_EX_BUBBLE_CNT_EN is defined.
- x0 / invalid gating:
  - i_rd_addr=0, i_ctrl=0x0003, i_valid=1 -> o_ctrl=0x0002.
  - i_valid=0, i_ctrl=0x0007 -> o_ctrl=0x0000.
- Counter saturation (CNT_WIDTH=4, ID_EX_BUBBLE_CNT_EN defined): 17 consecutive flushes -> o_bubble_cnt reaches 0xF and stays at 0xF.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with hold on stall and bubble insertion on flush.
// Optional flush counter on o_bubble_cnt when ID_EX_BUBBLE_CNT_EN is defined.
module id_ex_pipe_reg #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
`ifdef ID_EX_BUBBLE_CNT_EN
    parameter int unsigned CNT_WIDTH      = 16,
`endif
    parameter int unsigned CTRL_WIDTH     = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_stall,
    input  logic                      i_flush,
    input  logic                      i_valid,
    input  logic [DATA_WIDTH-1:0]     i_pc,
    input  logic [DATA_WIDTH-1:0]     i_rs1_data,
    input  logic [DATA_WIDTH-1:0]     i_rs2_data,
    input  logic [DATA_WIDTH-1:0]     i_imm,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] i_rs2_addr,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd_addr,
    input  logic [2:0]                i_funct3,
    input  logic [CTRL_WIDTH-1:0]     i_ctrl,
    output logic                      o_valid,
    output logic [DATA_WIDTH-1:0]     o_pc,
    output logic [DATA_WIDTH-1:0]     o_rs1_data,
    output logic [DATA_WIDTH-1:0]     o_rs2_data,
    output logic [DATA_WIDTH-1:0]     o_imm,
    output logic [REG_ADDR_WIDTH-1:0] o_rs1_addr,
    output logic [REG_ADDR_WIDTH-1:0] o_rs2_addr,
    output logic [REG_ADDR_WIDTH-1:0] o_rd_addr,
    output logic [2:0]                o_funct3,
`ifdef ID_EX_BUBBLE_CNT_EN
    output logic [CNT_WIDTH-1:0]      o_bubble_cnt,
`endif
    output logic [CTRL_WIDTH-1:0]     o_ctrl
);

    logic [CTRL_WIDTH-1:0] ctrl_load_c;

    // Invalid slots carry no side effects; x0 must never look like a forwarding source.
    always_comb begin
        ctrl_load_c = i_valid ? i_ctrl : '0;
        if (i_rd_addr == '0) begin
            ctrl_load_c[0] = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid    <= 1'b0;
            o_pc       <= '0;
            o_rs1_data <= '0;
            o_rs2_data <= '0;
            o_imm      <= '0;
            o_rs1_addr <= '0;
            o_rs2_addr <= '0;
            o_rd_addr  <= '0;
            o_funct3   <= '0;
            o_ctrl     <= '0;
        end else if (i_flush) begin
            o_valid    <= 1'b0;
            o_pc       <= '0;
            o_rs1_data <= '0;
            o_rs2_data <= '0;
            o_imm      <= '0;
            o_rs1_addr <= '0;
            o_rs2_addr <= '0;
            o_rd_addr  <= '0;
            o_funct3   <= '0;
            o_ctrl     <= '0;
        end else if (!i_stall) begin
            o_valid    <= i_valid;
            o_pc       <= i_pc;
            o_rs1_data <= i_rs1_data;
            o_rs2_data <= i_rs2_data;
            o_imm      <= i_imm;
            o_rs1_addr <= i_rs1_addr;
            o_rs2_addr <= i_rs2_addr;
            o_rd_addr  <= i_rd_addr;
            o_funct3   <= i_funct3;
            o_ctrl     <= ctrl_load_c;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    // Saturating count of inserted bubbles, independent of stall.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_bubble_cnt <= '0;
        end else if (i_flush && (o_bubble_cnt != '1)) begin
            o_bubble_cnt <= o_bubble_cnt + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: reset, load, stall, flush, ctrl gating, counter.
module tb_id_ex_pipe_reg;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned CW = 16;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_stall, i_flush, i_valid;
    logic [DW-1:0] i_pc, i_rs1_data, i_rs2_data, i_imm;
    logic [AW-1:0] i_rs1_addr, i_rs2_addr, i_rd_addr;
    logic [2:0]    i_funct3;
    logic [CW-1:0] i_ctrl;
    logic          o_valid;
    logic [DW-1:0] o_pc, o_rs1_data, o_rs2_data, o_imm;
    logic [AW-1:0] o_rs1_addr, o_rs2_addr, o_rd_addr;
    logic [2:0]    o_funct3;
    logic [CW-1:0] o_ctrl;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [3:0]    o_bubble_cnt;
`endif

    int errors = 0;
    int checks = 0;

    id_ex_pipe_reg #(
        .DATA_WIDTH    (DW),
        .REG_ADDR_WIDTH(AW),
`ifdef ID_EX_BUBBLE_CNT_EN
        .CNT_WIDTH     (4),
`endif
        .CTRL_WIDTH    (CW)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_stall     (i_stall),
        .i_flush     (i_flush),
        .i_valid     (i_valid),
        .i_pc        (i_pc),
        .i_rs1_data  (i_rs1_data),
        .i_rs2_data  (i_rs2_data),
        .i_imm       (i_imm),
        .i_rs1_addr  (i_rs1_addr),
        .i_rs2_addr  (i_rs2_addr),
        .i_rd_addr   (i_rd_addr),
        .i_funct3    (i_funct3),
        .i_ctrl      (i_ctrl),
        .o_valid     (o_valid),
        .o_pc        (o_pc),
        .o_rs1_data  (o_rs1_data),
        .o_rs2_data  (o_rs2_data),
        .o_imm       (o_imm),
        .o_rs1_addr  (o_rs1_addr),
        .o_rs2_addr  (o_rs2_addr),
        .o_rd_addr   (o_rd_addr),
        .o_funct3    (o_funct3),
`ifdef ID_EX_BUBBLE_CNT_EN
        .o_bubble_cnt(o_bubble_cnt),
`endif
        .o_ctrl      (o_ctrl)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs sampled there too.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst = 1'b1; i_stall = 1'b0; i_flush = 1'b0; i_valid = 1'b0;
        i_pc = '0; i_rs1_data = '0; i_rs2_data = '0; i_imm = '0;
        i_rs1_addr = '0; i_rs2_addr = '0; i_rd_addr = '0; i_funct3 = '0; i_ctrl = '0;
        step();
        step();
        check("rst_valid", 64'(o_valid), 64'h0);
        check("rst_pc",    64'(o_pc),    64'h0);
        check("rst_ctrl",  64'(o_ctrl),  64'h0);
`ifdef ID_EX_BUBBLE_CNT_EN
        check("rst_cnt",   64'(o_bubble_cnt), 64'h0);
`endif
        i_rst = 1'b0;

        // Load, then assert reset between edges
        i_valid = 1'b1; i_pc = 32'h0000_0040; i_rd_addr = 5'd1; i_ctrl = 16'h0001;
        step();
        check("pre_rst_pc", 64'(o_pc), 64'h40);
        #2 i_rst = 1'b1;
        #1;
        check("async_rst_pc",    64'(o_pc),    64'h0);
        check("async_rst_valid", 64'(o_valid), 64'h0);
        check("async_rst_ctrl",  64'(o_ctrl),  64'h0);
        check("async_rst_rd",    64'(o_rd_addr), 64'h0);
        step();
        i_rst = 1'b0;

        // Plain load
        i_valid = 1'b1; i_pc = 32'h100; i_rs1_data = 32'hDEADBEEF; i_rs2_data = 32'h1234_5678;
        i_imm = 32'hFFFF_FFF0; i_rs1_addr = 5'd3; i_rs2_addr = 5'd4; i_rd_addr = 5'd5;
        i_funct3 = 3'b101; i_ctrl = 16'h0001;
        step();
        check("load_pc",     64'(o_pc),       64'h100);
        check("load_rs1",    64'(o_rs1_data), 64'hDEADBEEF);
        check("load_rs2",    64'(o_rs2_data), 64'h12345678);
        check("load_imm",    64'(o_imm),      64'hFFFFFFF0);
        check("load_rs1a",   64'(o_rs1_addr), 64'd3);
        check("load_rs2a",   64'(o_rs2_addr), 64'd4);
        check("load_rd",     64'(o_rd_addr),  64'd5);
        check("load_funct3", 64'(o_funct3),   64'h5);
        check("load_ctrl",   64'(o_ctrl),     64'h0001);
        check("load_valid",  64'(o_valid),    64'h1);

        // Stall for 3 cycles with new inputs presented
        i_stall = 1'b1; i_pc = 32'h104; i_rs1_data = 32'hCAFE_F00D;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_pc",  64'(o_pc),       64'h100);
            check("stall_rs1", 64'(o_rs1_data), 64'hDEADBEEF);
        end
        i_stall = 1'b0;
        step();
        check("unstall_pc",  64'(o_pc),       64'h104);
        check("unstall_rs1", 64'(o_rs1_data), 64'hCAFEF00D);

        // Flush and stall together: bubble wins
        i_flush = 1'b1; i_stall = 1'b1;
        step();
        check("flush_valid", 64'(o_valid),   64'h0);
        check("flush_ctrl",  64'(o_ctrl),    64'h0);
        check("flush_rd",    64'(o_rd_addr), 64'h0);
        check("flush_pc",    64'(o_pc),      64'h0);
`ifdef ID_EX_BUBBLE_CNT_EN
        check("flush_cnt",   64'(o_bubble_cnt), 64'h1);
`endif
        i_flush = 1'b0;
        step();
        check("stall_after_flush_pc", 64'(o_pc), 64'h0);
`ifdef ID_EX_BUBBLE_CNT_EN
        check("stall_cnt_hold", 64'(o_bubble_cnt), 64'h1);
`endif
        i_stall = 1'b0;

        // x0 destination drops reg_write only
        i_valid = 1'b1; i_rd_addr = 5'd0; i_ctrl = 16'h0003; i_pc = 32'h180;
        step();
        check("x0_ctrl",  64'(o_ctrl),  64'h0002);
        check("x0_valid", 64'(o_valid), 64'h1);

        // Invalid slot clears the whole control bundle, other fields still copied
        i_valid = 1'b0; i_rd_addr = 5'd7; i_ctrl = 16'h0007; i_pc = 32'h200;
        step();
        check("inv_ctrl",  64'(o_ctrl),    64'h0);
        check("inv_valid", 64'(o_valid),   64'h0);
        check("inv_pc",    64'(o_pc),      64'h200);
        check("inv_rd",    64'(o_rd_addr), 64'd7);

        // Upper control bits pass when valid and rd != 0
        i_valid = 1'b1; i_ctrl = 16'hA5F7;
        step();
        check("full_ctrl", 64'(o_ctrl), 64'hA5F7);

`ifdef ID_EX_BUBBLE_CNT_EN
        // Saturation of the 4-bit counter over 17 flushes
        i_rst = 1'b1;
        #1;
        check("sat_rst_cnt", 64'(o_bubble_cnt), 64'h0);
        step();
        i_rst = 1'b0;
        i_flush = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            check("sat_cnt", 64'(o_bubble_cnt), (k > 15) ? 64'hF : 64'(k));
        end
        i_flush = 1'b0;
        step();
        check("sat_hold", 64'(o_bubble_cnt), 64'hF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
